i2c_master: RTL and testbench

I2C_MASTER -- requirements
Module: i2c_master

---
 rtl/i2c_master.sv | 176 +++++++++++++++++
 tb/tb_i2c_master.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/i2c_master.sv
// Single-master I2C byte transfer engine: START, address+R/W, one data byte (write or read), STOP.
// Every bit slot is four quarter-phases; SCL is low in q0/q1 and high in q2/q3.
//
// state   | meaning
// --------+-------------------------------------------------------------
// S_IDLE  | bus released, waiting for a rising edge on send
// S_START | SDA falls in q1 while SCL is high; SCL falls at q2
// S_ADDR  | shift out addr[6:0] and rw, MSB first
// S_ACK1  | SDA released, slave ACK/NACK sampled
// S_WDATA | shift out the latched data byte, MSB first
// S_RDATA | SDA released, 8 bits shifted in MSB first
// S_ACK2  | write: sample slave ACK; read: master NACK (SDA released)
// S_STOP  | SDA low in q0..q2, released in q3 while SCL is high
module i2c_master #(
  parameter int QUARTER = 125
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       send,
  input  logic [6:0] addr,
  input  logic       rw,
  input  logic [7:0] data,
  output logic [7:0] rd_data,
  output logic       busy,
  output logic       ack_err,
  inout  wire        sda,
  output logic       scl
);

  localparam int QW = (QUARTER > 1) ? $clog2(QUARTER) : 1;

  typedef enum logic [2:0] {
    S_IDLE, S_START, S_ADDR, S_ACK1, S_WDATA, S_RDATA, S_ACK2, S_STOP
  } state_t;

  state_t      state, state_nxt;
  logic [QW-1:0] qcnt;
  logic [1:0]  phase;
  logic [2:0]  bit_cnt;
  logic [7:0]  tx_sh;
  logic [7:0]  rx_sh;
  logic [7:0]  data_lat;
  logic        rw_lat;
  logic        ack_bit;
  logic        send_prev;
  logic        sda_low;
  logic        send_edge;
  logic        qend;
  logic        slot_end;
  logic        sample_now;

  assign send_edge  = send && !send_prev;
  assign qend       = (qcnt == QW'(QUARTER - 1));
  assign slot_end   = qend && (phase == 2'd3);
  // Sample one clk into q2 so SCL has already been high for a cycle.
  assign sample_now = (phase == 2'd2) && (qcnt == '0);

  assign sda = sda_low ? 1'b0 : 1'bz;

  always_comb begin
    state_nxt = state;
    scl       = 1'b1;
    sda_low   = 1'b0;
    case (state)
      S_IDLE: begin
        if (send_edge) state_nxt = S_START;
      end
      S_START: begin
        scl     = !phase[1];
        sda_low = (phase != 2'd0);
        if (slot_end) state_nxt = S_ADDR;
      end
      S_ADDR: begin
        scl     = phase[1];
        sda_low = !tx_sh[7];
        if (slot_end && bit_cnt == 3'd7) state_nxt = S_ACK1;
      end
      S_ACK1: begin
        scl = phase[1];
        if (slot_end) begin
          if (ack_bit)     state_nxt = S_STOP;
          else if (rw_lat) state_nxt = S_RDATA;
          else             state_nxt = S_WDATA;
        end
      end
      S_WDATA: begin
        scl     = phase[1];
        sda_low = !tx_sh[7];
        if (slot_end && bit_cnt == 3'd7) state_nxt = S_ACK2;
      end
      S_RDATA: begin
        scl = phase[1];
        if (slot_end && bit_cnt == 3'd7) state_nxt = S_ACK2;
      end
      S_ACK2: begin
        scl = phase[1];
        if (slot_end) state_nxt = S_STOP;
      end
      S_STOP: begin
        scl     = phase[1];
        sda_low = (phase != 2'd3);
        if (slot_end) state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= S_IDLE;
      qcnt      <= '0;
      phase     <= 2'd0;
      bit_cnt   <= 3'd0;
      tx_sh     <= 8'd0;
      rx_sh     <= 8'd0;
      data_lat  <= 8'd0;
      rw_lat    <= 1'b0;
      ack_bit   <= 1'b0;
      send_prev <= 1'b0;
      busy      <= 1'b0;
      ack_err   <= 1'b0;
      rd_data   <= 8'd0;
    end else begin
      send_prev <= send;
      state     <= state_nxt;
      if (state == S_IDLE) begin
        qcnt    <= '0;
        phase   <= 2'd0;
        bit_cnt <= 3'd0;
        if (send_edge) begin
          tx_sh    <= {addr, rw};
          data_lat <= data;
          rw_lat   <= rw;
          ack_err  <= 1'b0;
          busy     <= 1'b1;
        end
      end else begin
        if (qend) begin
          qcnt  <= '0;
          phase <= phase + 2'd1;
        end else begin
          qcnt <= qcnt + QW'(1);
        end

        if (sample_now) begin
          if (state == S_ACK1 || state == S_ACK2) ack_bit <= sda;
          if (state == S_RDATA) rx_sh <= {rx_sh[6:0], sda};
        end

        if (slot_end) begin
          case (state)
            S_ADDR, S_WDATA: begin
              tx_sh   <= {tx_sh[6:0], 1'b0};
              bit_cnt <= bit_cnt + 3'd1;
            end
            S_ACK1: begin
              if (ack_bit) ack_err <= 1'b1;
              else         tx_sh   <= data_lat;
            end
            S_RDATA: begin
              bit_cnt <= bit_cnt + 3'd1;
              if (bit_cnt == 3'd7) rd_data <= rx_sh;
            end
            S_ACK2: begin
              // A read ends with our own NACK, which must not flag an error.
              if (!rw_lat && ack_bit) ack_err <= 1'b1;
            end
            S_STOP: busy <= 1'b0;
            default: ;
          endcase
        end
      end
    end
  end

endmodule

// File: tb/tb_i2c_master.sv
// Randomized bench for i2c_master: a bus monitor logs START/STOP and SDA at each SCL rise,
// a behavioural slave answers, and a transaction-level model predicts log, busy time and flags.
module tb_i2c_master;

  localparam int Q = 4;

  logic       clk = 1'b0;
  logic       rst;
  logic       send;
  logic [6:0] addr;
  logic       rw;
  logic [7:0] data;
  wire  [7:0] rd_data;
  wire        busy;
  wire        ack_err;
  wire        scl;
  wire        sda_bus;
  logic       slave_low = 1'b0;

  pullup (sda_bus);
  assign sda_bus = slave_low ? 1'b0 : 1'bz;

  always #5 clk = ~clk;

  i2c_master #(.QUARTER(Q)) dut (
    .clk     (clk),
    .rst     (rst),
    .send    (send),
    .addr    (addr),
    .rw      (rw),
    .data    (data),
    .rd_data (rd_data),
    .busy    (busy),
    .ack_err (ack_err),
    .sda     (sda_bus),
    .scl     (scl)
  );

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Bus log tokens: 0/1 = SDA at an SCL rise, 2 = START, 3 = STOP.
  localparam int T_START = 2;
  localparam int T_STOP  = 3;

  int   log_q[$];
  int   exp_q[$];
  int   busy_cycles = 0;
  int   rise_cnt = 0;
  int   start_cnt = 0;
  logic prev_scl = 1'b1;
  logic prev_sda = 1'b1;

  logic       sl_present = 1'b0;
  logic       sl_rw = 1'b0;
  logic       sl_ack2 = 1'b0;
  logic [7:0] sl_rbyte = 8'd0;

  // Slot index counts SCL pulses after START: 0..7 address byte, 8 ACK1, 9..16 data, 17 ACK2.
  function automatic logic want_low(input int idx);
    if (!sl_present) return 1'b0;
    if (idx == 8) return 1'b1;
    if (sl_rw && idx >= 9 && idx <= 16) return !sl_rbyte[16 - idx];
    if (!sl_rw && idx == 17) return sl_ack2;
    return 1'b0;
  endfunction

  always @(negedge clk) begin
    logic cs, ds;
    cs = (scl === 1'b1);
    ds = (sda_bus !== 1'b0);
    if (busy === 1'b1) busy_cycles++;
    if (prev_scl && cs && prev_sda && !ds) begin
      log_q.push_back(T_START);
      start_cnt++;
      rise_cnt  = 0;
      slave_low = 1'b0;
    end else if (prev_scl && cs && !prev_sda && ds) begin
      log_q.push_back(T_STOP);
    end
    if (!prev_scl && cs) begin
      log_q.push_back(ds ? 1 : 0);
      rise_cnt++;
    end
    if (prev_scl && !cs) slave_low = want_low(rise_cnt);
    prev_scl = cs;
    prev_sda = ds;
  end

  logic [7:0] rd_model = 8'd0;
  int         exp_busy;
  logic       exp_err;

  // Transaction-level prediction of what appears on the bus.
  task automatic build_expected(input logic [6:0] a, input logic r, input logic [7:0] d,
                                input logic pres, input logic ack2, input logic [7:0] rb);
    logic [7:0] first;
    exp_q.delete();
    first = {a, r};
    exp_q.push_back(T_START);
    for (int i = 7; i >= 0; i--) exp_q.push_back(int'(first[i]));
    if (!pres) begin
      exp_q.push_back(1);
      exp_busy = 11 * 4 * Q;
      exp_err  = 1'b1;
    end else begin
      exp_q.push_back(0);
      for (int i = 7; i >= 0; i--) exp_q.push_back(r ? int'(rb[i]) : int'(d[i]));
      exp_q.push_back(r ? 1 : (ack2 ? 0 : 1));
      exp_busy = 20 * 4 * Q;
      exp_err  = !r && !ack2;
      if (r) rd_model = rb;
    end
    exp_q.push_back(0);
    exp_q.push_back(T_STOP);
  endtask

  task automatic setup_txn(input logic [6:0] a, input logic r, input logic [7:0] d,
                           input logic pres, input logic ack2, input logic [7:0] rb);
    addr = a; rw = r; data = d;
    sl_present = pres; sl_rw = r; sl_ack2 = ack2; sl_rbyte = rb;
    log_q.delete();
    busy_cycles = 0;
    start_cnt = 0;
  endtask

  // mode: 0 = plain pulse, 1 = extra send pulse mid-transfer, 2 = send held high afterwards.
  task automatic run_txn(input string tag, input logic [6:0] a, input logic r, input logic [7:0] d,
                         input logic pres, input logic ack2, input logic [7:0] rb,
                         input int mode, input bit armed);
    int k;
    if (!armed) begin
      @(negedge clk);
      setup_txn(a, r, d, pres, ack2, rb);
      send = 1'b1;
    end
    @(negedge clk);
    check({tag, "_busy_set"}, busy, 1'b1);
    addr = 7'($urandom); data = 8'($urandom); rw = 1'($urandom);
    if (mode != 2) send = 1'b0;
    if (mode == 1) begin
      repeat (40) @(negedge clk);
      send = 1'b1;
      @(negedge clk);
      send = 1'b0;
    end
    k = 0;
    while (busy === 1'b1 && k < 3000) begin
      @(negedge clk);
      k++;
    end
    check({tag, "_done"}, busy, 1'b0);
    repeat (20) @(negedge clk);
    check({tag, "_no_restart"}, busy, 1'b0);
    send = 1'b0;
    build_expected(a, r, d, pres, ack2, rb);
    check({tag, "_starts"}, start_cnt, 1);
    check({tag, "_log_len"}, log_q.size(), exp_q.size());
    for (int i = 0; i < exp_q.size(); i++)
      check($sformatf("%s_tok%0d", tag, i), (i < log_q.size()) ? log_q[i] : -1, exp_q[i]);
    check({tag, "_busy_cycles"}, busy_cycles, exp_busy);
    check({tag, "_ack_err"}, ack_err, exp_err);
    check({tag, "_rd_data"}, rd_data, rd_model);
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int k;
    rst = 1'b1; send = 1'b0; addr = 7'd0; rw = 1'b0; data = 8'd0;
    repeat (4) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("rst_scl", scl, 1'b1);
    check("rst_sda", sda_bus !== 1'b0, 1'b1);
    check("rst_busy", busy, 1'b0);
    check("rst_ack_err", ack_err, 1'b0);
    check("rst_rd_data", rd_data, 8'h00);

    run_txn("wr_1a_a5", 7'h1A, 1'b0, 8'hA5, 1'b1, 1'b1, 8'h00, 0, 1'b0);
    run_txn("addr_nack", 7'h1A, 1'b0, 8'hA5, 1'b0, 1'b0, 8'h00, 0, 1'b0);
    run_txn("rd_3c", 7'h1A, 1'b1, 8'h00, 1'b1, 1'b0, 8'h3C, 0, 1'b0);
    run_txn("mid_pulse", 7'h55, 1'b0, 8'h0F, 1'b1, 1'b1, 8'h00, 1, 1'b0);
    run_txn("hold_send", 7'h2B, 1'b0, 8'hC3, 1'b1, 1'b0, 8'h00, 2, 1'b0);

    // Abort in the middle of the write data byte.
    @(negedge clk);
    setup_txn(7'h1A, 1'b0, 8'hA5, 1'b1, 1'b1, 8'h00);
    send = 1'b1;
    @(negedge clk);
    send = 1'b0;
    k = 0;
    while (rise_cnt < 11 && k < 1000) begin
      @(negedge clk);
      k++;
    end
    check("rst_wait_wdata", rise_cnt >= 11, 1'b1);
    rst = 1'b1;
    @(posedge clk);
    #1;
    check("abort_scl", scl, 1'b1);
    check("abort_sda", sda_bus !== 1'b0, 1'b1);
    check("abort_busy", busy, 1'b0);
    check("abort_rd_data", rd_data, 8'h00);
    rd_model = 8'd0;
    // send already high when reset releases must start a transfer on the first edge.
    @(negedge clk);
    setup_txn(7'h1A, 1'b0, 8'hA5, 1'b1, 1'b1, 8'h00);
    send = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    run_txn("after_rst", 7'h1A, 1'b0, 8'hA5, 1'b1, 1'b1, 8'h00, 0, 1'b1);

    for (int t = 0; t < 30; t++) begin
      run_txn($sformatf("rnd%0d", t), 7'($urandom), 1'($urandom), 8'($urandom),
              ($urandom_range(0, 3) != 0), 1'($urandom), 8'($urandom),
              int'($urandom_range(0, 2)), 1'b0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
